// File: rtl/fir_pkg.sv
// fir_pkg: constants and helpers shared by fir_16tap and its downstream stages.
//   DATA_W      sample width (Q1.15 signed)
//   FIR_LATENCY fir_16tap pipeline depth in enabled cycles
//   Q15_MAX/MIN representable Q1.15 range
//   sat16()     clamp an integer into the Q1.15 range
package fir_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned FIR_LATENCY = 9;
  localparam int          Q15_MAX     = 32767;
  localparam int          Q15_MIN     = -32768;

  typedef logic signed [DATA_W-1:0] sample_t;

  function automatic logic signed [15:0] sat16(input int v);
    logic signed [15:0] r;
    if (v > Q15_MAX)      r = 16'sh7fff;
    else if (v < Q15_MIN) r = 16'sh8000;
    else                  r = v[15:0];
    return r;
  endfunction

endpackage

// File: rtl/fir_out_decimator_fifo.sv
// sync_fifo: single-clock FIFO with count-derived occupancy.
//   clk, rst   clock, synchronous active-high reset
//   push, din  write request and data (ignored when full unless popping same edge)
//   pop        read request (ignored when empty)
//   dout       head entry, zero when empty
//   full/empty occupancy flags
//   fill       current occupancy 0..DEPTH
module sync_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  // One extra bit over the pointer width; occupancy is the difference.
  logic [AW:0] wr_cnt, rd_cnt;
  logic        do_push, do_pop;

  always_comb begin
    fill    = wr_cnt - rd_cnt;
    full    = (fill == (AW+1)'(DEPTH));
    empty   = (fill == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = empty ? '0 : mem[rd_cnt[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (do_push) wr_cnt <= wr_cnt + 1'b1;
      if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_cnt[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_out_decimator.sv
// fir_out_decimator: drops fir_16tap warm-up samples, decimates by 2^k and
// buffers results for a valid/ready consumer.
// Build option: define FIR_DECIM_AVG_EN to average each group (rounded,
// saturated) instead of picking its last sample.
//   clk, rst    clock, synchronous active-high reset
//   en_in       sample enable shared with fir_16tap
//   y_in        filter output, Q1.15 signed
//   decim_log2  decimation exponent k (clamped to MAX_LOG2)
//   m_data      FIFO head sample
//   m_valid     FIFO non-empty
//   m_ready     consumer accept
//   overflow    sticky: a decimated sample was lost on a full FIFO
//   fill        FIFO occupancy
module fir_out_decimator
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W   = fir_pkg::DATA_W,
  parameter int unsigned LATENCY  = fir_pkg::FIR_LATENCY,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MAX_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_in,
  input  logic signed [DATA_W-1:0]  y_in,
  input  logic [2:0]                decim_log2,
  output logic signed [DATA_W-1:0]  m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    fill
);

  localparam int unsigned WARM_W = $clog2(LATENCY + 1);
  localparam int unsigned PH_W   = (MAX_LOG2 < 1) ? 1 : MAX_LOG2;

  logic [WARM_W-1:0] warm_q;
  logic [2:0]        k_q, k_cur;
  logic [PH_W-1:0]   phase_q, phase_base, grp_last;
  logic              accept, restart, complete;
  logic              push, pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] result;

  always_comb begin
    k_cur      = (decim_log2 > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : decim_log2;
    restart    = (k_cur != k_q);
    accept     = en_in && (warm_q == WARM_W'(LATENCY));
    grp_last   = PH_W'((32'd1 << k_cur) - 32'd1);
    // A k change abandons the partial group; this edge's sample opens a new one.
    phase_base = restart ? '0 : phase_q;
    complete   = (phase_base == grp_last);
    push       = accept && complete;
    pop        = m_valid && m_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q   <= '0;
      k_q      <= '0;
      phase_q  <= '0;
      overflow <= 1'b0;
    end else begin
      k_q <= k_cur;
      if (en_in && (warm_q != WARM_W'(LATENCY))) warm_q <= warm_q + 1'b1;
      if (accept)       phase_q <= complete ? '0 : phase_base + 1'b1;
      else if (restart) phase_q <= '0;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int unsigned ACC_W = DATA_W + MAX_LOG2;

  logic signed [ACC_W-1:0] acc_q, acc_base, acc_sum;
  logic        [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   acc_rnd, acc_shift;

  always_comb begin
    acc_base  = restart ? '0 : acc_q;
    acc_sum   = acc_base + {{MAX_LOG2{y_in[DATA_W-1]}}, y_in};
    rnd       = (k_cur == 3'd0) ? '0 : ((ACC_W+1)'(1) << (k_cur - 3'd1));
    acc_rnd   = {acc_sum[ACC_W-1], acc_sum} + rnd;
    acc_shift = acc_rnd >>> k_cur;
    result    = sat16(int'(acc_shift));
  end

  always_ff @(posedge clk) begin
    if (rst)          acc_q <= '0;
    else if (accept)  acc_q <= complete ? '0 : acc_sum;
    else if (restart) acc_q <= '0;
  end
`else
  always_comb result = y_in;
`endif

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (result),
    .pop   (pop),
    .dout  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  assign m_valid = !fifo_empty;

endmodule
